// File: rtl/oh_csa_accum.sv
// Framed multi-operand accumulator: 3:2 carry-save per beat, chunked carry-propagate resolve.
// Optional CSA_ACCUM_SIGNED_EN: operands are two's complement and sign-extended.
module oh_csa_accum #(
  parameter int DW  = 8,
  parameter int GW  = 4,
  parameter int CPW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW+GW-1:0] out_data,
  output logic             out_ovf,
  input  logic             out_ready
);
  localparam int AW = DW + GW;
  localparam int NR = AW / CPW;
  localparam int KW = (NR > 1) ? $clog2(NR) : 1;
  localparam int CW = GW + 1;
  localparam logic [CW-1:0] CMAX = {1'b1, {GW{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] s, c, r, x, c2;
  logic [CW-1:0] count;
  logic          ovf, cin;
  logic [KW-1:0] k;
  logic          accept, handshake;
  logic [CPW:0]  chunk_sum;
  int            kidx;

  always_comb begin
`ifdef CSA_ACCUM_SIGNED_EN
    x = {{GW{in_data[DW-1]}}, in_data};
`else
    x = {{GW{1'b0}}, in_data};
`endif
    // Carry vector is weighted one bit up; its MSB falls off (mod 2**AW).
    c2        = {c[AW-2:0], 1'b0};
    kidx      = int'(k) * CPW;
    chunk_sum = {1'b0, s[kidx +: CPW]} + {1'b0, c2[kidx +: CPW]} + {{CPW{1'b0}}, cin};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_ovf   = 1'b0;
    handshake = 1'b0;
    // IDLE already holds cleared state, so it accepts beats like ACCUM once reset drops.
    if (state == ACCUM || (state == IDLE && !reset)) in_ready = 1'b1;
    accept = in_valid & in_ready;
    case (state)
      IDLE:    state_nxt = (accept && in_last) ? RESOLVE : ACCUM;
      ACCUM:   if (accept && in_last) state_nxt = RESOLVE;
      RESOLVE: if (k == KW'(NR - 1)) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        out_data  = r;
        out_ovf   = ovf;
        handshake = out_ready;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s     <= '0;
      c     <= '0;
      r     <= '0;
      count <= '0;
      ovf   <= 1'b0;
      cin   <= 1'b0;
      k     <= '0;
    end else begin
      if (accept) begin
        s <= s ^ c2 ^ x;
        c <= (s & c2) | (s & x) | (c2 & x);
        if (count == CMAX) ovf   <= 1'b1;
        else               count <= count + 1'b1;
        if (in_last) begin
          cin <= 1'b0;
          k   <= '0;
        end
      end
      if (state == RESOLVE) begin
        r[kidx +: CPW] <= chunk_sum[CPW-1:0];
        cin            <= chunk_sum[CPW];
        k              <= k + 1'b1;
      end
      if (handshake) begin
        s     <= '0;
        c     <= '0;
        count <= '0;
        ovf   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_oh_csa_accum.sv
// Directed + randomized bench for oh_csa_accum (DW=8, GW=4, CPW=4); reference is plain integer summation.
module tb_oh_csa_accum;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_last, in_ready, out_valid, out_ovf, out_ready;
  logic [7:0]  in_data;
  logic [11:0] out_data;
  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  logic [7:0]  frame[$];

  always #5 clk = ~clk;

  oh_csa_accum #(.DW(8), .GW(4), .CPW(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] model_sum();
    int acc = 0;
    foreach (frame[i]) begin
`ifdef CSA_ACCUM_SIGNED_EN
      acc += int'($signed(frame[i]));
`else
      acc += int'(frame[i]);
`endif
    end
    return acc[11:0];
  endfunction

  task automatic send_frame();
    for (int i = 0; i < frame.size(); i++) begin
      int n = 0;
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = (i == frame.size() - 1);
      while (!in_ready && n < 50) begin
        tick();
        n++;
      end
      chk("beat_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic [11:0] exp_d, input logic exp_o,
                              input int hold);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_ovf"}, out_ovf, exp_o);
    chk({tag, "_busy"}, in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'b1;
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_data"}, out_data, exp_d);
      chk({tag, "_hold_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    frame = '{8'h01, 8'h02, 8'h03};
    send_frame();
    finish_frame("f123", 12'h006, 1'b0, 0);

    frame.delete();
    for (int i = 0; i < 16; i++) frame.push_back(8'hFF);
    send_frame();
`ifdef CSA_ACCUM_SIGNED_EN
    finish_frame("ff16", 12'hFF0, 1'b0, 0);
`else
    finish_frame("ff16", 12'hFF0, 1'b0, 0);
`endif

    frame.push_back(8'hFF);
    send_frame();
`ifdef CSA_ACCUM_SIGNED_EN
    finish_frame("ff17", 12'hFEF, 1'b1, 0);
`else
    finish_frame("ff17", 12'h0EF, 1'b1, 0);
`endif

    frame = '{8'h80};
    send_frame();
`ifdef CSA_ACCUM_SIGNED_EN
    finish_frame("single80", 12'hF80, 1'b0, 0);
    frame = '{8'h7F, 8'h81};
    send_frame();
    finish_frame("s7f81", 12'h000, 1'b0, 0);
    frame = '{8'hFF, 8'hFF};
    send_frame();
    finish_frame("sffff", 12'hFFE, 1'b0, 0);
`else
    finish_frame("single80", 12'h080, 1'b0, 0);
`endif

    frame = '{8'h11, 8'h22};
    send_frame();
    finish_frame("hold10", 12'h033, 1'b0, 10);
    frame = '{8'h01};
    send_frame();
    finish_frame("after_hold", 12'h001, 1'b0, 0);

    frame = '{8'h09, 8'h0A};
    send_frame();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_rel_ready", in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_no_out", out_valid, 0);
    end
    frame = '{8'h05};
    send_frame();
    finish_frame("after_rst", 12'h005, 1'b0, 0);

    for (int f = 0; f < 8; f++) begin
      int len = (f == 0) ? 20 : int'($urandom_range(1, 20));
      frame.delete();
      for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
      send_frame();
      finish_frame("rand", model_sum(), frame.size() > 16, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
